// File: rtl/ocp_sram_slave_pkg.sv
// Shared OCP command/response codes and default bus widths for the SRAM slave.
package ocp_sram_slave_pkg;

    localparam int OCP_ADDR_WIDTH = 32;
    localparam int OCP_DATA_WIDTH = 32;

    localparam logic [2:0] OCP_CMD_IDLE  = 3'b000;
    localparam logic [2:0] OCP_CMD_WRITE = 3'b001;
    localparam logic [2:0] OCP_CMD_READ  = 3'b010;

    localparam logic [1:0] OCP_RESP_NULL = 2'b00;
    localparam logic [1:0] OCP_RESP_DVA  = 2'b01;
    localparam logic [1:0] OCP_RESP_ERR  = 2'b11;

    function automatic logic ocp_cmd_is_rw(input logic [2:0] cmd);
        return (cmd == OCP_CMD_WRITE) || (cmd == OCP_CMD_READ);
    endfunction

endpackage

// File: rtl/ocp_sram_array.sv
// Single-port word memory built from independent byte lanes; each lane has its own
// write enable, read is asynchronously indexed (the parent registers the result).
module ocp_sram_array #(
    parameter int DEPTH      = 1024,
    parameter int DATA_WIDTH = 32,
    parameter int BEN_WIDTH  = DATA_WIDTH / 8,
    parameter int AW         = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [AW-1:0]         idx,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [BEN_WIDTH-1:0]  wr_ben,
    output logic [DATA_WIDTH-1:0] rd_data
);

    genvar gi;
    generate
        for (gi = 0; gi < BEN_WIDTH; gi++) begin : g_lane
            logic [7:0] lane_q [DEPTH];

            always_ff @(posedge clk) begin
                if (wr_en && wr_ben[gi]) begin
                    lane_q[idx] <= wr_data[8*gi +: 8];
                end
            end

            assign rd_data[8*gi +: 8] = lane_q[idx];
        end
    endgenerate

endmodule

// File: rtl/ocp_sram_slave.sv
// OCP single-beat memory slave: accepts one command at a time, waits WAIT_STATES
// cycles, then returns one registered response beat.
module ocp_sram_slave
    import ocp_sram_slave_pkg::*;
#(
    parameter int DEPTH       = 1024,
    parameter int WAIT_STATES = 0,
    parameter int READ_ONLY   = 0,
    parameter int ADDR_WIDTH  = OCP_ADDR_WIDTH,
    parameter int DATA_WIDTH  = OCP_DATA_WIDTH,
    parameter int BEN_WIDTH   = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] i_MAddr,
    input  logic [2:0]            i_MCmd,
    input  logic [DATA_WIDTH-1:0] i_MData,
    input  logic [BEN_WIDTH-1:0]  i_MByteEn,
    output logic                  o_SCmdAccept,
    output logic [DATA_WIDTH-1:0] o_SData,
    output logic [1:0]            o_SResp
);

    localparam int         AW       = $clog2(DEPTH);
    localparam logic [3:0] WAIT_CNT = 4'(WAIT_STATES);

    typedef enum logic [2:0] {
        ST_IDLE = 3'b001,
        ST_WAIT = 3'b010,
        ST_RESP = 3'b100
    } state_t;

    state_t                state_q, state_d;
    logic [3:0]            cnt_q, cnt_d;
    logic [AW-1:0]         idx_q, idx_d;
    logic                  err_q, err_d;
    logic                  wr_q, wr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [BEN_WIDTH-1:0]  ben_q, ben_d;
    logic [1:0]            resp_q, resp_d;
    logic [DATA_WIDTH-1:0] sdata_q, sdata_d;

    logic                  in_err;
    logic                  resp_enter;
    logic [AW-1:0]         cur_idx;
    logic                  cur_err, cur_wr;
    logic [DATA_WIDTH-1:0] cur_wdata;
    logic [BEN_WIDTH-1:0]  cur_ben;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  mem_we;
    logic                  unused_addr_lsbs;

    assign unused_addr_lsbs = ^i_MAddr[1:0];

    assign in_err = (i_MAddr[ADDR_WIDTH-1:AW+2] != '0)
                 || !ocp_cmd_is_rw(i_MCmd)
                 || ((i_MCmd == OCP_CMD_WRITE) && (READ_ONLY != 0));

    // With zero wait states the response edge is the accept edge, so the live
    // inputs stand in for the command latch while idle.
    assign cur_idx   = (state_q == ST_IDLE) ? i_MAddr[AW+1:2]                : idx_q;
    assign cur_err   = (state_q == ST_IDLE) ? in_err                         : err_q;
    assign cur_wr    = (state_q == ST_IDLE) ? (i_MCmd == OCP_CMD_WRITE)      : wr_q;
    assign cur_wdata = (state_q == ST_IDLE) ? i_MData                        : wdata_q;
    assign cur_ben   = (state_q == ST_IDLE) ? i_MByteEn                      : ben_q;

    // Gating with rst keeps a write presented while reset is held out of memory.
    assign mem_we = resp_enter && cur_wr && !cur_err && !rst;

    ocp_sram_array #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (DATA_WIDTH),
        .BEN_WIDTH  (BEN_WIDTH),
        .AW         (AW)
    ) u_array (
        .clk     (clk),
        .wr_en   (mem_we),
        .idx     (cur_idx),
        .wr_data (cur_wdata),
        .wr_ben  (cur_ben),
        .rd_data (rd_data)
    );

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        err_d      = err_q;
        wr_d       = wr_q;
        wdata_d    = wdata_q;
        ben_d      = ben_q;
        resp_d     = OCP_RESP_NULL;
        sdata_d    = '0;
        resp_enter = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (i_MCmd != OCP_CMD_IDLE) begin
                    idx_d   = i_MAddr[AW+1:2];
                    err_d   = in_err;
                    wr_d    = (i_MCmd == OCP_CMD_WRITE);
                    wdata_d = i_MData;
                    ben_d   = i_MByteEn;
                    if (WAIT_STATES == 0) begin
                        state_d    = ST_RESP;
                        resp_enter = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = 4'd1;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == WAIT_CNT) begin
                    state_d    = ST_RESP;
                    cnt_d      = 4'd0;
                    resp_enter = 1'b1;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase

        if (resp_enter) begin
            if (cur_err) begin
                resp_d = OCP_RESP_ERR;
            end else begin
                resp_d = OCP_RESP_DVA;
                if (!cur_wr) begin
                    sdata_d = rd_data;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= '0;
            err_q   <= 1'b0;
            wr_q    <= 1'b0;
            wdata_q <= '0;
            ben_q   <= '0;
            resp_q  <= OCP_RESP_NULL;
            sdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            wr_q    <= wr_d;
            wdata_q <= wdata_d;
            ben_q   <= ben_d;
            resp_q  <= resp_d;
            sdata_q <= sdata_d;
        end
    end

    assign o_SCmdAccept = (state_q == ST_IDLE);
    assign o_SResp      = resp_q;
    assign o_SData      = sdata_q;

endmodule

// File: tb/tb_ocp_sram_slave.sv
// Bench for ocp_sram_slave: three instances (0 wait states, 3 wait states, read-only)
// checked every cycle against a transaction-level model, plus literal expectations.
module tb_ocp_sram_slave;
    import ocp_sram_slave_pkg::*;

    localparam int NI = 3;
    localparam int WS_T [NI] = '{0, 3, 0};
    localparam int RO_T [NI] = '{0, 0, 1};

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] maddr [NI];
    logic [2:0]  mcmd  [NI];
    logic [31:0] mdata [NI];
    logic [3:0]  mben  [NI];

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < NI; gi++) begin : g_dut
        logic        acc;
        logic [1:0]  resp;
        logic [31:0] sdata;

        ocp_sram_slave #(
            .DEPTH       (1024),
            .WAIT_STATES (WS_T[gi]),
            .READ_ONLY   (RO_T[gi])
        ) u_dut (
            .clk          (clk),
            .rst          (rst),
            .i_MAddr      (maddr[gi]),
            .i_MCmd       (mcmd[gi]),
            .i_MData      (mdata[gi]),
            .i_MByteEn    (mben[gi]),
            .o_SCmdAccept (acc),
            .o_SData      (sdata),
            .o_SResp      (resp)
        );

        // Transaction model: edge numbers of the accept, the response and the next
        // free slot; memory changes only when the response edge is reached.
        int          e       = 0;
        int          free_e  = 0;
        int          resp_e  = -1;
        logic [2:0]  p_cmd   = 3'b000;
        logic [31:0] p_addr  = 32'h0;
        logic [31:0] p_data  = 32'h0;
        logic [3:0]  p_ben   = 4'h0;
        logic        exp_acc = 1'b1;
        logic [1:0]  exp_resp = 2'b00;
        logic [31:0] exp_data = 32'h0;
        bit          exp_dk  = 1'b1;
        logic [31:0] mmem [1024];
        bit          mval [1024];

        initial begin : model
            int w;
            forever begin
                @(posedge clk or posedge rst);
                if (rst) begin
                    e = 0; free_e = 0; resp_e = -1;
                    exp_acc = 1'b1; exp_resp = OCP_RESP_NULL; exp_data = 32'h0; exp_dk = 1'b1;
                end else begin
                    e++;
                    exp_resp = OCP_RESP_NULL; exp_data = 32'h0; exp_dk = 1'b1;
                    if (e >= free_e && mcmd[gi] != OCP_CMD_IDLE) begin
                        p_cmd = mcmd[gi]; p_addr = maddr[gi]; p_data = mdata[gi]; p_ben = mben[gi];
                        resp_e = e + WS_T[gi];
                        free_e = e + WS_T[gi] + 2;
                    end
                    if (e == resp_e) begin
                        w = int'(p_addr >> 2);
                        if (w >= 1024 || !(p_cmd == OCP_CMD_WRITE || p_cmd == OCP_CMD_READ)
                            || (p_cmd == OCP_CMD_WRITE && RO_T[gi] != 0)) begin
                            exp_resp = OCP_RESP_ERR;
                        end else if (p_cmd == OCP_CMD_WRITE) begin
                            exp_resp = OCP_RESP_DVA;
                            for (int b = 0; b < 4; b++)
                                if (p_ben[b]) mmem[w][8*b +: 8] = p_data[8*b +: 8];
                            if (p_ben == 4'hF) mval[w] = 1'b1;
                        end else begin
                            exp_resp = OCP_RESP_DVA;
                            exp_data = mmem[w];
                            exp_dk   = mval[w];
                        end
                    end
                    exp_acc = (e + 1 >= free_e);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, req, $time);
    endtask

    task automatic cmp_inst(input int i, input logic a, input logic ea, input logic [1:0] r,
                            input logic [1:0] er, input logic [31:0] d, input logic [31:0] ed,
                            input bit dk);
        chk($sformatf("model_acc[%0d]", i), 32'(a), 32'(ea));
        chk($sformatf("model_resp[%0d]", i), 32'(r), 32'(er));
        if (dk) chk($sformatf("model_data[%0d]", i), d, ed);
    endtask

    initial begin : compare
        forever begin
            @(negedge clk);
            cmp_inst(0, g_dut[0].acc, g_dut[0].exp_acc, g_dut[0].resp, g_dut[0].exp_resp,
                     g_dut[0].sdata, g_dut[0].exp_data, g_dut[0].exp_dk);
            cmp_inst(1, g_dut[1].acc, g_dut[1].exp_acc, g_dut[1].resp, g_dut[1].exp_resp,
                     g_dut[1].sdata, g_dut[1].exp_data, g_dut[1].exp_dk);
            cmp_inst(2, g_dut[2].acc, g_dut[2].exp_acc, g_dut[2].resp, g_dut[2].exp_resp,
                     g_dut[2].sdata, g_dut[2].exp_data, g_dut[2].exp_dk);
        end
    end

    function automatic logic get_acc(input int i);
        case (i)
            0: return g_dut[0].acc;
            1: return g_dut[1].acc;
            default: return g_dut[2].acc;
        endcase
    endfunction

    function automatic logic [1:0] get_resp(input int i);
        case (i)
            0: return g_dut[0].resp;
            1: return g_dut[1].resp;
            default: return g_dut[2].resp;
        endcase
    endfunction

    function automatic logic [31:0] get_data(input int i);
        case (i)
            0: return g_dut[0].sdata;
            1: return g_dut[1].sdata;
            default: return g_dut[2].sdata;
        endcase
    endfunction

    // Presents a command and returns at the posedge that accepts it (plus #1).
    task automatic issue(input int i, input logic [2:0] c, input logic [31:0] a,
                         input logic [31:0] d, input logic [3:0] b);
        bit ok = 1'b0;
        mcmd[i] = c; maddr[i] = a; mdata[i] = d; mben[i] = b;
        for (int k = 0; k < 40 && !ok; k++) begin
            @(negedge clk);
            ok = get_acc(i);
        end
        if (!ok) begin
            n_total++;
            $display("FAIL accept_wait[%0d]: no accept within 40 cycles", i);
        end
        @(posedge clk); #1;
        mcmd[i] = OCP_CMD_IDLE;
    endtask

    task automatic txn(input int i, input logic [2:0] c, input logic [31:0] a,
                       input logic [31:0] d, input logic [3:0] b,
                       output logic [1:0] r, output logic [31:0] q);
        issue(i, c, a, d, b);
        repeat (WS_T[i]) @(posedge clk);
        @(negedge clk);
        r = get_resp(i);
        q = get_data(i);
        $display("txn inst=%0d cmd=%0d addr=%h wdata=%h ben=%h -> resp=%0d rdata=%h",
                 i, c, a, d, b, r, q);
        @(posedge clk); #1;
    endtask

    initial begin : stim
        logic [1:0]  r;
        logic [31:0] q;
        for (int i = 0; i < NI; i++) begin
            mcmd[i] = OCP_CMD_IDLE; maddr[i] = 32'h0; mdata[i] = 32'h0; mben[i] = 4'h0;
        end
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_acc", 32'(get_acc(0)), 32'd1);
        chk("reset_resp", 32'(get_resp(0)), 32'(OCP_RESP_NULL));
        chk("reset_data", get_data(0), 32'h0);
        rst = 1'b0;
        @(posedge clk); #1;

        txn(0, OCP_CMD_WRITE, 32'h10, 32'hDEADBEEF, 4'hF, r, q);
        chk("t1_wr_resp", 32'(r), 32'(OCP_RESP_DVA));
        chk("t1_wr_data", q, 32'h0);
        txn(0, OCP_CMD_READ, 32'h10, 32'h0, 4'hF, r, q);
        chk("t2_rd_resp", 32'(r), 32'(OCP_RESP_DVA));
        chk("t2_rd_data", q, 32'hDEADBEEF);
        txn(0, OCP_CMD_WRITE, 32'h10, 32'h11223344, 4'b0101, r, q);
        txn(0, OCP_CMD_READ, 32'h10, 32'h0, 4'h0, r, q);
        chk("t3_merge_data", q, 32'hDE22BE44);
        txn(0, OCP_CMD_WRITE, 32'h10, 32'hFFFFFFFF, 4'h0, r, q);
        chk("ben0_resp", 32'(r), 32'(OCP_RESP_DVA));
        txn(0, OCP_CMD_READ, 32'h13, 32'h0, 4'h0, r, q);
        chk("ben0_lsb_rd_data", q, 32'hDE22BE44);

        // Command held across the response: accepted again in the next idle cycle.
        mcmd[0] = OCP_CMD_READ; maddr[0] = 32'h10;
        repeat (4) @(posedge clk);
        #1 mcmd[0] = OCP_CMD_IDLE;
        repeat (2) @(posedge clk);
        #1;

        txn(0, OCP_CMD_READ, 32'h1000, 32'h0, 4'hF, r, q);
        chk("t5_oor_resp", 32'(r), 32'(OCP_RESP_ERR));
        chk("t5_oor_data", q, 32'h0);
        txn(0, 3'b111, 32'h10, 32'h0, 4'hF, r, q);
        chk("t5_badcmd_resp", 32'(r), 32'(OCP_RESP_ERR));
        txn(0, OCP_CMD_WRITE, 32'h1010, 32'h0BADF00D, 4'hF, r, q);
        chk("t5_oor_wr_resp", 32'(r), 32'(OCP_RESP_ERR));
        txn(0, OCP_CMD_READ, 32'h10, 32'h0, 4'hF, r, q);
        chk("t5_no_alias_data", q, 32'hDE22BE44);

        txn(1, OCP_CMD_WRITE, 32'h20, 32'hA5A5A5A5, 4'hF, r, q);
        chk("t4_wr_resp", 32'(r), 32'(OCP_RESP_DVA));
        txn(1, OCP_CMD_READ, 32'h20, 32'h0, 4'hF, r, q);
        chk("t4_rd_resp", 32'(r), 32'(OCP_RESP_DVA));
        chk("t4_rd_data", q, 32'hA5A5A5A5);

        issue(1, OCP_CMD_WRITE, 32'h20, 32'h12345678, 4'hF);
        rst = 1'b1;
        #1;
        chk("t6_rst_acc", 32'(get_acc(1)), 32'd1);
        chk("t6_rst_resp", 32'(get_resp(1)), 32'(OCP_RESP_NULL));
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        txn(1, OCP_CMD_READ, 32'h20, 32'h0, 4'hF, r, q);
        chk("t6_readback_data", q, 32'hA5A5A5A5);

        txn(2, OCP_CMD_READ, 32'h0, 32'h0, 4'hF, r, q);
        chk("ro_rd_resp", 32'(r), 32'(OCP_RESP_DVA));
        txn(2, OCP_CMD_WRITE, 32'h0, 32'hCAFEF00D, 4'hF, r, q);
        chk("ro_wr_resp", 32'(r), 32'(OCP_RESP_ERR));
        chk("ro_wr_data", q, 32'h0);
        txn(2, OCP_CMD_READ, 32'h0, 32'h0, 4'hF, r, q);
        chk("ro_rd2_resp", 32'(r), 32'(OCP_RESP_DVA));

        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

endmodule
